operand_serializer: RTL and testbench
=====================================

OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning the number of operand bits shifted per lane per transaction (legal 1..32).
REQ-002 SHALL provide parameter SETTLE, default 2, meaning idle cycles between the last shifted bit and the first result sample (legal 0..15).
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  operand set offered.
REQ-006 SHALL provide port in_ready  output  1  block accepts an operand set.
REQ-007 SHALL provide port op_a, op_b, op_c  input  32 each  operands for serial lanes 0, 1 and 2; only bits [WIDTH-1:0] are used.
REQ-008 SHALL provide port ser_out  output  3  serial lanes {c,b,a} driven to the size-exploration top ui_in[2:0].
REQ-009 SHALL provide port sel  output  1  byte-select driven to ui_in[7].
REQ-010 SHALL provide port dut_lo  input  8  DUT uo_out: result[7:0] when sel=1, result[15:8] when sel=0.
REQ-011 SHALL provide port dut_hi  input  8  DUT uio_out: result[23:16] when sel=1, result[31:24] when sel=0.
REQ-012 SHALL provide port res_valid  output  1  captured result available.
REQ-013 SHALL provide port res_ready  input  1  consumer accepts the result.
REQ-014 SHALL provide port res_data  output  32  reassembled DUT result.

Function
REQ-015 SHALL implement states IDLE, SHIFT, SETTLE, READ1, READ0, DONE, held in a registered state variable.
REQ-016 In IDLE, in_ready SHALL be 1; in_ready SHALL be 0 in every other state.
REQ-017 On a clock edge with IDLE and in_valid=1, op_a/op_b/op_c SHALL be latched into shift registers, a bit counter SHALL be loaded with WIDTH-1, and the state SHALL become SHIFT.
REQ-018 In SHIFT, ser_out[i] SHALL be a registered output equal to operand_i[k], where k is the counter value; k counts down from WIDTH-1 to 0, one bit per cycle (MSB first).
REQ-019 After WIDTH SHIFT cycles the DUT lane registers SHALL hold operand_i[WIDTH-1:0] in bits [WIDTH-1:0]; the block SHALL then enter SETTLE, or enter READ1 directly when SETTLE=0.
REQ-020 ser_out SHALL be 3'b000 in every state other than SHIFT.
REQ-021 SETTLE SHALL last exactly SETTLE cycles, counted by a 4-bit counter.
REQ-022 sel SHALL be 1 in all states except READ0, where it SHALL be 0.
REQ-023 On the edge ending READ1, res_data[7:0] SHALL be loaded from dut_lo and res_data[23:16] from dut_hi.
REQ-024 On the edge ending READ0, res_data[15:8] SHALL be loaded from dut_lo and res_data[31:24] from dut_hi; the state SHALL then become DONE.
REQ-025 READ1 and READ0 SHALL last one cycle each.
REQ-026 In DONE, res_valid SHALL be 1 and res_data SHALL be held stable until res_ready=1.
REQ-027 The state SHALL return to IDLE on the edge where res_valid and res_ready are both 1.
REQ-028 res_valid SHALL be 0 outside DONE.
REQ-029 Latency from the accept edge to res_valid=1 SHALL be WIDTH+SETTLE+2 cycles.
REQ-030 in_valid SHALL be ignored outside IDLE, and operand inputs SHALL be ignored after the latch.
REQ-031 res_ready SHALL be ignored outside DONE.
REQ-032 res_data SHALL retain its last captured value through IDLE until the next READ1 overwrites it.

Reset
REQ-033 While reset=1 at a clock edge, the state SHALL become IDLE, and in_ready SHALL read 1 in the following cycle.
REQ-034 While reset=1 at a clock edge, ser_out, res_valid and res_data SHALL be cleared to 0, sel SHALL be 1, and all counters and shift registers SHALL be cleared to 0.
REQ-035 Reset asserted in any state, mid-shift included, SHALL abort the transaction, and no res_valid SHALL be produced for it.

Verification
REQ-036 WIDTH=8, SETTLE=2, adder DUT, op_a=0x5A, op_b=0xC3 -> ser_out[0] sequence 0,1,0,1,1,0,1,0; res_valid 12 cycles after accept; res_data=0x0000011D.
REQ-037 Stub DUT returning result 0xDEADBEEF -> sel high then low across READ1/READ0; res_data=0xDEADBEEF.
REQ-038 res_ready held 0 for 5 cycles in DONE -> res_valid=1 and res_data constant for all 5 cycles; in_ready=0 until the cycle after the handshake.
REQ-039 in_valid=1 continuously with back-to-back operand sets -> each set is accepted only in IDLE; no operand is skipped or duplicated.
REQ-040 reset pulsed at SHIFT bit 3 -> ser_out=0 and in_ready=1 next cycle; a new transaction then yields a correct result.
REQ-041 WIDTH=32, SETTLE=0, multiplier DUT, op_a=0xFFFF, op_b=0xFFFF -> latency 34 cycles; res_data=0xFFFE0001.

Source files
------------

// File: rtl/operand_serializer.sv
// Feeds three operands bit-serially (MSB first) into a size-exploration DUT, waits
// for it to settle, then reads its 32-bit result back in two byte-select phases.
module operand_serializer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_c,
    output logic [2:0]  ser_out,
    output logic        sel,
    input  logic [7:0]  dut_lo,
    input  logic [7:0]  dut_hi,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data
);

    localparam int CW = 5;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in ST_IDLE, res_valid only in ST_DONE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETTLE,
        ST_READ1,
        ST_READ0,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_sh_c;
    logic [WIDTH-1:0]   w_sh_a_nxt;
    logic [WIDTH-1:0]   w_sh_b_nxt;
    logic [WIDTH-1:0]   w_sh_c_nxt;
    logic [CW-1:0]      r_bit_cnt;
    logic [3:0]         r_settle_cnt;
    logic [2:0]         r_ser_out;
    logic [31:0]        r_res_data;
    logic               w_unused_ops;

    // Operand bits above WIDTH never reach the DUT.
    assign w_unused_ops = ^{op_a, op_b, op_c};

    assign w_sh_a_nxt = r_sh_a << 1;
    assign w_sh_b_nxt = r_sh_b << 1;
    assign w_sh_c_nxt = r_sh_c << 1;

    assign ser_out  = r_ser_out;
    assign res_data = r_res_data;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        sel         = 1'b1;
        res_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_bit_cnt == '0) w_state_nxt = (SETTLE == 0) ? ST_READ1 : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == 4'(SETTLE - 1)) w_state_nxt = ST_READ1;
            end
            ST_READ1: w_state_nxt = ST_READ0;
            ST_READ0: begin
                sel         = 1'b0;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sh_a       <= '0;
            r_sh_b       <= '0;
            r_sh_c       <= '0;
            r_bit_cnt    <= '0;
            r_settle_cnt <= '0;
            r_ser_out    <= '0;
            r_res_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sh_a    <= op_a[WIDTH-1:0];
                        r_sh_b    <= op_b[WIDTH-1:0];
                        r_sh_c    <= op_c[WIDTH-1:0];
                        r_bit_cnt <= CW'(WIDTH - 1);
                        r_ser_out <= {op_c[WIDTH-1], op_b[WIDTH-1], op_a[WIDTH-1]};
                    end
                end
                ST_SHIFT: begin
                    // The shift registers keep the bit currently on the lanes at their MSB.
                    r_sh_a       <= w_sh_a_nxt;
                    r_sh_b       <= w_sh_b_nxt;
                    r_sh_c       <= w_sh_c_nxt;
                    r_settle_cnt <= '0;
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                        r_ser_out <= {w_sh_c_nxt[WIDTH-1], w_sh_b_nxt[WIDTH-1], w_sh_a_nxt[WIDTH-1]};
                    end else begin
                        r_ser_out <= '0;
                    end
                end
                ST_SETTLE: r_settle_cnt <= r_settle_cnt + 4'd1;
                ST_READ1: begin
                    r_res_data[7:0]   <= dut_lo;
                    r_res_data[23:16] <= dut_hi;
                end
                ST_READ0: begin
                    r_res_data[15:8]  <= dut_lo;
                    r_res_data[31:24] <= dut_hi;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: two configurations (8/2 and 32/0) driven against a
// behavioural DUT stand-in, checked every cycle against a cycle-count based model.
module tb_operand_serializer;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][31:0] op_a;
    logic [1:0][31:0] op_b;
    logic [1:0][31:0] op_c;
    logic [1:0][2:0]  ser_out;
    logic [1:0]       sel;
    logic [1:0][7:0]  dut_lo;
    logic [1:0][7:0]  dut_hi;
    logic [1:0]       res_valid;
    logic [1:0]       res_ready;
    logic [1:0][31:0] res_data;

    int checks   = 0;
    int failures = 0;
    int sb_pops  = 0;
    logic started = 1'b0;

    int          mode [2];
    logic [31:0] lane_a [2];
    logic [31:0] lane_b [2];
    logic [31:0] lane_c [2];

    logic [1:0]  m_busy = 2'b00;
    int          m_c [2];
    int          m_accepts [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic [31:0] m_cc [2];
    logic [31:0] m_res [2];
    logic [31:0] m_last [2];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    operand_serializer #(.WIDTH(8), .SETTLE(2)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .op_c(op_c[0]), .ser_out(ser_out[0]), .sel(sel[0]),
        .dut_lo(dut_lo[0]), .dut_hi(dut_hi[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .res_data(res_data[0])
    );

    operand_serializer #(.WIDTH(32), .SETTLE(0)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .op_c(op_c[1]), .ser_out(ser_out[1]), .sel(sel[1]),
        .dut_lo(dut_lo[1]), .dut_hi(dut_hi[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .res_data(res_data[1])
    );

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 32;
    endfunction

    function automatic int stl(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] msk(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // 0: adder, 1: multiplier, other: constant stub
    function automatic logic [31:0] dut_fn(input int md, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        case (md)
            0:       return a + b + c;
            1:       return a * b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // DUT stand-in: result bytes muxed by sel from its lane registers.
    always_comb begin
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            r = dut_fn(mode[i], lane_a[i] & msk(wid(i)), lane_b[i] & msk(wid(i)),
                       lane_c[i] & msk(wid(i)));
            dut_lo[i] = sel[i] ? r[7:0]   : r[15:8];
            dut_hi[i] = sel[i] ? r[23:16] : r[31:24];
        end
    end

    // Lanes of the stand-in, result scoreboard for u_dut8, and the reference model.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                lane_a[i] = '0;
                lane_b[i] = '0;
                lane_c[i] = '0;
            end else if (m_busy[i] && m_c[i] < wid(i)) begin
                lane_a[i] = {lane_a[i][30:0], ser_out[i][0]};
                lane_b[i] = {lane_b[i][30:0], ser_out[i][1]};
                lane_c[i] = {lane_c[i][30:0], ser_out[i][2]};
            end

            if (i == 0 && !reset && res_valid[0] && res_ready[0]) begin
                chk("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("sb_result", res_data[0], exp_q.pop_front());
                sb_pops++;
            end

            if (reset) begin
                m_busy[i] = 1'b0;
                m_last[i] = '0;
                if (i == 0) exp_q.delete();
            end else if (!m_busy[i]) begin
                if (in_valid[i]) begin
                    m_busy[i] = 1'b1;
                    m_c[i]    = 0;
                    m_a[i]    = op_a[i] & msk(wid(i));
                    m_b[i]    = op_b[i] & msk(wid(i));
                    m_cc[i]   = op_c[i] & msk(wid(i));
                    m_res[i]  = dut_fn(mode[i], m_a[i], m_b[i], m_cc[i]);
                    m_accepts[i]++;
                    if (i == 0) exp_q.push_back(m_res[i]);
                end
            end else if (m_c[i] >= wid(i) + stl(i) + 2) begin
                if (res_ready[i]) m_busy[i] = 1'b0;
            end else begin
                m_c[i]++;
                if (m_c[i] == wid(i) + stl(i) + 2) m_last[i] = m_res[i];
            end
        end
    end

    // m_c counts edges since accept: shifting for c < W, reads at c = W+S and W+S+1, done after.
    always @(negedge clk) begin
        int w, s, c, k;
        logic [2:0]  es;
        logic [31:0] ed;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                w  = wid(i);
                s  = stl(i);
                c  = m_c[i];
                es = 3'b000;
                if (m_busy[i] && c < w) begin
                    k  = w - 1 - c;
                    es = {m_cc[i][k], m_b[i][k], m_a[i][k]};
                end
                if (m_busy[i] && c >= w + s + 2)      ed = m_res[i];
                else if (m_busy[i] && c == w + s + 1) ed = {m_last[i][31:24], m_res[i][23:16],
                                                            m_last[i][15:8], m_res[i][7:0]};
                else                                  ed = m_last[i];
                chk($sformatf("u%0d in_ready", i), 32'(in_ready[i]), 32'(!m_busy[i]));
                chk($sformatf("u%0d ser_out", i), 32'(ser_out[i]), 32'(es));
                chk($sformatf("u%0d sel", i), 32'(sel[i]), 32'(!(m_busy[i] && c == w + s + 1)));
                chk($sformatf("u%0d res_valid", i), 32'(res_valid[i]),
                    32'(m_busy[i] && c >= w + s + 2));
                chk($sformatf("u%0d res_data", i), res_data[i], ed);
            end
        end
    end

    task automatic run_txn(input int i, input int md, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input int hold, input int exp_lat,
                           input logic [31:0] exp_res, input logic [31:0] exp_seq);
        int lat;
        int w;
        logic [31:0] seq;
        w          = wid(i);
        mode[i]    = md;
        op_a[i]    = a;
        op_b[i]    = b;
        op_c[i]    = c;
        in_valid[i] = 1'b1;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        op_a[i]    = ~a;
        op_b[i]    = ~b;
        op_c[i]    = ~c;
        seq = {31'b0, ser_out[i][0]};
        lat = 0;
        while (res_valid[i] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat < w) seq = {seq[30:0], ser_out[i][0]};
        end
        chk($sformatf("u%0d latency", i), 32'(lat), 32'(exp_lat));
        chk($sformatf("u%0d lane0 sequence", i), seq & msk(w), exp_seq);
        chk($sformatf("u%0d result", i), res_data[i], exp_res);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("u%0d held res_valid", i), 32'(res_valid[i]), 32'd1);
            chk($sformatf("u%0d held res_data", i), res_data[i], exp_res);
        end
        res_ready[i] = 1'b1;
        @(posedge clk); #1;
        res_ready[i] = 1'b0;
        chk($sformatf("u%0d in_ready after handshake", i), 32'(in_ready[i]), 32'd1);
        chk($sformatf("u%0d res_valid after handshake", i), 32'(res_valid[i]), 32'd0);
    endtask

    logic [31:0] b2b_a [4] = '{32'h01, 32'hF0, 32'hAA, 32'h80};
    logic [31:0] b2b_b [4] = '{32'h02, 32'h0F, 32'h55, 32'h80};
    logic [31:0] b2b_c [4] = '{32'h03, 32'h00, 32'h01, 32'h80};

    initial begin
        int base_acc, base_pops, guard;
        reset     = 1'b1;
        in_valid  = '0;
        res_ready = '0;
        op_a      = '0;
        op_b      = '0;
        op_c      = '0;
        mode[0]   = 0;
        mode[1]   = 1;
        m_accepts[0] = 0;
        m_accepts[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d reset in_ready", i), 32'(in_ready[i]), 32'd1);
            chk($sformatf("u%0d reset ser_out", i), 32'(ser_out[i]), 32'd0);
            chk($sformatf("u%0d reset sel", i), 32'(sel[i]), 32'd1);
            chk($sformatf("u%0d reset res_valid", i), 32'(res_valid[i]), 32'd0);
            chk($sformatf("u%0d reset res_data", i), res_data[i], 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(0, 0, 32'h5A, 32'hC3, 32'h00, 0, 12, 32'h0000_011D, 32'h5A);
        run_txn(0, 2, 32'h12, 32'h34, 32'h56, 5, 12, 32'hDEAD_BEEF, 32'h12);
        run_txn(0, 0, 32'hABCD_12FF, 32'hFF, 32'h0077_00FF, 0, 12, 32'h0000_02FD, 32'hFF);
        run_txn(1, 1, 32'hFFFF, 32'hFFFF, 32'h0, 0, 34, 32'hFFFE_0001, 32'h0000_FFFF);
        run_txn(1, 0, 32'h8000_0001, 32'h7FFF_FFFF, 32'h1, 2, 34, 32'h0000_0001, 32'h8000_0001);

        // Back-to-back: in_valid and res_ready held high across four operand sets.
        mode[0]      = 0;
        base_acc     = m_accepts[0];
        base_pops    = sb_pops;
        res_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            op_a[0] = b2b_a[j];
            op_b[0] = b2b_b[j];
            op_c[0] = b2b_c[j];
            guard = 0;
            while (m_accepts[0] != base_acc + j + 1 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        in_valid[0] = 1'b0;
        guard = 0;
        while (sb_pops != base_pops + 4 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        res_ready[0] = 1'b0;
        chk("b2b results delivered", 32'(sb_pops - base_pops), 32'd4);
        chk("b2b last result", res_data[0], 32'h0000_0180);

        // Reset in the middle of shifting, at bit 3.
        mode[0]     = 0;
        op_a[0]     = 32'h3C;
        op_b[0]     = 32'h11;
        op_c[0]     = 32'h22;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bit3 ser_out", 32'(ser_out[0]), 32'h1);
        base_pops = sb_pops;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort ser_out", 32'(ser_out[0]), 32'd0);
        chk("abort in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort res_data", res_data[0], 32'd0);
        res_ready[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        res_ready[0] = 1'b0;
        chk("abort no result", 32'(sb_pops - base_pops), 32'd0);
        run_txn(0, 0, 32'h3C, 32'h11, 32'h22, 0, 12, 32'h0000_006F, 32'h3C);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
